truth_table_sweeper: RTL and testbench
======================================

# truth_table_sweeper

Sequencer that exhaustively characterises one 3-input combinational logic gate. On `start` it drives every input combination `{in1,in2,in3}` = 000..111 onto the gate, waits a programmable settle time per row, and samples the gate output. It assembles the measured 8-bit truth table in the codebase's function-number encoding and compares it against an expected value. It sits between a test/configuration host and any 3-input gate module, for example a `0xNN` function block.

## Interface
Parameters:
- `SETTLE_CYCLES`, 4, cycles each row is held before sampling; legal range 1..255.

Ports:
- `clk` input 1, single clock; all logic is rising-edge.
- `rst` input 1, reset, asynchronous and active-high.
- `start` input 1, sweep request; sampled only in IDLE.
- `expected` input 8, expected function number; latched when `start` is accepted.
- `in1`, `in2`, `in3` output 1 each, gate inputs; `in1` is the MSB of the row index.
- `gate_out` input 1, output of the gate under test.
- `busy` output 1, high from start acceptance until `done`.
- `done` output 1, one-cycle completion pulse.
- `table` output 8, measured function number.
- `match` output 1, `table == expected`; valid when `done` pulses, held afterwards.
- `fail` output 1, at least one row mismatched.
- `fail_row` output 3, lowest mismatching row index; 0 if `fail` = 0.

## Operation
- Encoding: row r = `{in1,in2,in3}`. The sample for row r is written to `table[7-r]`. Row 000 maps to the MSB, so a gate named `0x63` yields `table` = 8'h63.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE, `start`=1 → SETTLE:
  - row ← 0
  - settle counter ← 0
  - `table`, `fail`, `fail_row`, `match` ← 0
  - `expected` latched
  - `busy` ← 1
- SETTLE: drives row r on `in1..in3` and increments the counter. When the counter reaches `SETTLE_CYCLES-1` → SAMPLE.
- SAMPLE: one cycle. Row r is still driven.
  - `table[7-r]` ← `gate_out`.
  - If `gate_out` ≠ `expected_q[7-r]` and `fail` = 0: `fail` ← 1, `fail_row` ← r.
  - If r = 7 → DONE. Otherwise r ← r+1, counter ← 0 → SETTLE.
- DONE: one cycle.
  - `done` = 1.
  - `match` ← (`table` == `expected_q`).
  - `busy` ← 0 on exit.
  - → IDLE.
- IDLE holds `in1..in3` at the last driven row. Results hold until the next accepted `start`.
- `start` while not in IDLE is ignored; there is no queuing.
- `expected` changes after acceptance have no effect.

## Timing
- Reset value of every output is 0: `in1..in3`, `busy`, `done`, `table`, `match`, `fail`, `fail_row`. FSM resets to IDLE, row and counter reset to 0.
- `rst` asserted mid-sweep aborts immediately and asynchronously to reset values. No `done` pulse is produced.
- `start` accepted at edge 0 gives `busy` = 1 and row 0 driven after edge 0.
- Each row occupies `SETTLE_CYCLES`+1 cycles. The sample is taken at the edge ending the SAMPLE cycle.
- `done` is high for the single cycle after the last SAMPLE. Start-to-`done` latency is 8·(`SETTLE_CYCLES`+1)+1 cycles: 41 at the default.
- Rows change only at SAMPLE→SETTLE edges, so `in1..in3` never glitch mid-row.
- `start` asserted in the DONE cycle is ignored. `start` asserted in the first IDLE cycle after DONE is accepted.

## Configuration
- `TT_SWEEP_EARLY_ABORT_EN` defined:
  - A mismatch in SAMPLE goes directly to DONE.
  - Unvisited rows keep their bits at 0 in `table`.
  - `fail` = 1, `fail_row` = the failing row, `match` = 0.
  - Latency becomes (r+1)·(`SETTLE_CYCLES`+1)+1.
- Undefined: all 8 rows are always swept, and `fail_row` reports the lowest mismatching row.

## Test plan
- Gate model = function 0x63, `expected`=8'h63, `SETTLE_CYCLES`=4:
  - `done` at cycle 41, `table`=8'h63, `match`=1, `fail`=0, `fail_row`=0.
- Same gate, `expected`=8'h67, macro undefined:
  - `table`=8'h63, `match`=0, `fail`=1, `fail_row`=5.
- Same gate, `expected`=8'hE3, macro defined:
  - `done` at cycle 6 after start, `fail_row`=0, `table`=8'h00, `match`=0.
- Gate model with a 3-cycle propagation delay, `SETTLE_CYCLES`=4:
  - `table` equals the true function number. With `SETTLE_CYCLES`=1 a mismatch is reported.
- `start` re-pulsed during the sweep, then `rst` asserted at cycle 20:
  - The re-pulse is ignored.
  - All outputs are 0 immediately, no `done` pulse.
  - The next `start` gives a full, correct sweep.
- Back-to-back: `start` held high continuously:
  - A new sweep begins the cycle after each DONE→IDLE.
  - `done` pulses every 42 cycles.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives every row {in1,in2,in3} = 000..111 onto a
// 3-input gate, waits SETTLE_CYCLES per row, samples gate_out and builds the
// measured function number (row r lands in bit 7-r) for comparison against
// an expected value.
//
// Handshake: start is a level request taken only in IDLE; busy is high from
// acceptance through the DONE cycle; done is a one-cycle pulse; results hold
// until the next accepted start.
//
// Optional feature: define TT_SWEEP_EARLY_ABORT_EN to stop the sweep at the
// first mismatching row.
//
// The measured function number is the port meas_table (`table` is a reserved
// word). fsm_state exposes the FSM state for observation.
module truth_table_sweeper #(
   parameter int SETTLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] expected,
   output logic       in1,
   output logic       in2,
   output logic       in3,
   input  logic       gate_out,
   output logic       busy,
   output logic       done,
   output logic [7:0] meas_table,
   output logic       match,
   output logic       fail,
   output logic [2:0] fail_row,
   output logic [1:0] fsm_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t     state;
   state_t     state_n;
   logic [2:0] row;
   logic [7:0] cnt;
   logic [7:0] expected_q;
   logic [7:0] table_q;
   logic       fail_q;
   logic [2:0] fail_row_q;
   logic       match_q;
   logic       mismatch;
   logic [7:0] sampled_table;

   // Current row's sample merged into the table, and its mismatch flag.
   always_comb begin
      sampled_table = table_q;
      sampled_table[3'd7 - row] = gate_out;
      mismatch = (gate_out != expected_q[3'd7 - row]);
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Next-state logic.
   always_comb begin
      state_n = state;
      case (state)
         IDLE:   if (start) state_n = SETTLE;
         SETTLE: if (cnt == 8'(SETTLE_CYCLES - 1)) state_n = SAMPLE;
         SAMPLE: begin
`ifdef TT_SWEEP_EARLY_ABORT_EN
            if (row == 3'd7 || mismatch) state_n = DONE;
            else                         state_n = SETTLE;
`else
            if (row == 3'd7) state_n = DONE;
            else             state_n = SETTLE;
`endif
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Row/counter sequencing and result capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row        <= 3'd0;
         cnt        <= 8'd0;
         expected_q <= 8'd0;
         table_q    <= 8'd0;
         fail_q     <= 1'b0;
         fail_row_q <= 3'd0;
         match_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  row        <= 3'd0;
                  cnt        <= 8'd0;
                  expected_q <= expected;
                  table_q    <= 8'd0;
                  fail_q     <= 1'b0;
                  fail_row_q <= 3'd0;
                  match_q    <= 1'b0;
               end
            end
            SETTLE: cnt <= cnt + 8'd1;
            SAMPLE: begin
               table_q <= sampled_table;
               // Only the first (lowest) mismatching row is recorded.
               if (mismatch && !fail_q) begin
                  fail_q     <= 1'b1;
                  fail_row_q <= row;
               end
               // match is settled on entry to DONE so it is valid with done.
               if (state_n == DONE) begin
                  match_q <= (sampled_table == expected_q);
               end else begin
                  row <= row + 3'd1;
                  cnt <= 8'd0;
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs: row drives the gate directly so inputs only move at row changes.
   always_comb begin
      {in1, in2, in3} = row;
      busy       = (state != IDLE);
      done       = (state == DONE);
      meas_table = table_q;
      match      = match_q;
      fail       = fail_q;
      fail_row   = fail_row_q;
      fsm_state  = state;
   end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: a gate model (ideal or 3-cycle delayed)
// feeds the DUT; a model predicts each sweep's result, which is queued at
// start and compared when done pulses.
module tb_truth_table_sweeper;

   localparam int S = 4;
   localparam int W = 21;  // {table[8], match, fail, fail_row[3], latency[8]}

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] expected = 8'd0;
   logic       in1, in2, in3;
   logic       gate_out;
   logic       busy, done, match, fail;
   logic [7:0] meas_table;
   logic [2:0] fail_row;
   logic [1:0] fsm_state;

   // Second instance with a too-short settle time.
   logic       start_s = 1'b0;
   logic       in1_s, in2_s, in3_s, gate_out_s;
   logic       busy_s, done_s, match_s, fail_s;
   logic [7:0] table_s;
   logic [2:0] fail_row_s;
   logic [1:0] fsm_state_s;

   logic [7:0] f_num = 8'h63;
   logic       use_delay = 1'b0;
   logic [2:0] dly = 3'd0;
   logic [2:0] dly_s = 3'd0;
   logic       ideal, ideal_s;

   logic [W-1:0] exp_q[$];
   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   logic busy_d = 1'b0;
   int edge_n = 0;
   int last_done = -1;
   logic b2b = 1'b0;

   truth_table_sweeper #(.SETTLE_CYCLES(S)) u_dut (
      .clk(clk), .rst(rst), .start(start), .expected(expected),
      .in1(in1), .in2(in2), .in3(in3), .gate_out(gate_out),
      .busy(busy), .done(done), .meas_table(meas_table), .match(match),
      .fail(fail), .fail_row(fail_row), .fsm_state(fsm_state)
   );

   truth_table_sweeper #(.SETTLE_CYCLES(1)) u_slow (
      .clk(clk), .rst(rst), .start(start_s), .expected(8'h63),
      .in1(in1_s), .in2(in2_s), .in3(in3_s), .gate_out(gate_out_s),
      .busy(busy_s), .done(done_s), .meas_table(table_s), .match(match_s),
      .fail(fail_s), .fail_row(fail_row_s), .fsm_state(fsm_state_s)
   );

   // clock / gate models
   always #5 clk = ~clk;

   always_comb begin
      ideal    = f_num[3'd7 - {in1, in2, in3}];
      ideal_s  = f_num[3'd7 - {in1_s, in2_s, in3_s}];
      gate_out = use_delay ? dly[2] : ideal;
      gate_out_s = dly_s[2];
   end

   always @(posedge clk) begin
      dly   <= {dly[1:0], ideal};
      dly_s <= {dly_s[1:0], ideal_s};
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [W-1:0] model(input logic [7:0] f, input logic [7:0] e, input int s);
      logic [7:0] diff;
      logic [7:0] t;
      logic       fl;
      logic [2:0] r;
      int         lat;
      diff = f ^ e;
      t = f;
      fl = 1'b0;
      r = 3'd0;
      lat = 8 * (s + 1) + 1;
      for (int i = 0; i < 8; i++) begin
         if (diff[7 - i] && !fl) begin
            fl = 1'b1;
            r = 3'(i);
         end
      end
`ifdef TT_SWEEP_EARLY_ABORT_EN
      if (fl) begin
         t = f & (8'hFF << (3'd7 - r));
         lat = (int'(r) + 1) * (s + 1) + 1;
      end
`endif
      return {t, (t == e), fl, r, 8'(lat)};
   endfunction

   // scoreboard: compare on every done pulse
   always @(posedge clk) begin
      #1;
      edge_n++;
      if (rst) begin
         busy_d = 1'b0;
         check("done_in_reset", {31'd0, done}, 32'd0);
      end else begin
         if (busy && !busy_d) cyc = 1;
         else cyc++;
         busy_d = busy;
         if (done) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               logic [W-1:0] e;
               e = exp_q.pop_front();
               check("table",    {24'd0, meas_table}, {24'd0, e[20:13]});
               check("match",    {31'd0, match},      {31'd0, e[12]});
               check("fail",     {31'd0, fail},       {31'd0, e[11]});
               check("fail_row", {29'd0, fail_row},   {29'd0, e[10:8]});
               check("latency",  cyc,                 {24'd0, e[7:0]});
            end
            if (b2b && last_done >= 0) check("done_period", edge_n - last_done, 42);
            last_done = edge_n;
         end
      end
   end

   // driver tasks
   task automatic pulse_start(input logic [7:0] f, input logic [7:0] e);
      @(negedge clk);
      f_num = f;
      expected = e;
      exp_q.push_back(model(f, e, S));
      start = 1'b1;
      @(posedge clk);
      #1;
      check("busy_on_accept", {31'd0, busy}, 32'd1);
      check("row0_on_accept", {29'd0, in1, in2, in3}, 32'd0);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) begin
         check("timeout", 32'd1, 32'd0);
         exp_q.delete();
      end
   endtask

   task automatic check_all_zero(input string tag);
      check(tag, {17'd0, in1, in2, in3, busy, done, meas_table, match, fail, fail_row}, 32'd0);
   endtask

   initial begin
      // reset
      repeat (3) @(negedge clk);
      check_all_zero("reset_outputs");
      check("reset_state", {30'd0, fsm_state}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // nominal, single-row mismatch, row-0 mismatch
      pulse_start(8'h63, 8'h63); wait_idle(200);
      pulse_start(8'h63, 8'h67); wait_idle(200);
      pulse_start(8'h63, 8'hE3); wait_idle(200);

      // random functions and expectations
      for (int i = 0; i < 4; i++) begin
         logic [7:0] rf;
         rf = 8'($urandom_range(0, 255));
         pulse_start(rf, (i[0]) ? rf : 8'($urandom_range(0, 255)));
         wait_idle(200);
      end

      // expected changed after acceptance is ignored
      pulse_start(8'hA5, 8'hA5);
      repeat (5) @(negedge clk);
      expected = 8'h00;
      wait_idle(200);

      // 3-cycle gate delay, adequate settle
      use_delay = 1'b1;
      pulse_start(8'h63, 8'h63); wait_idle(200);
      use_delay = 1'b0;

      // re-pulse mid-sweep, then reset at cycle 20
      pulse_start(8'h63, 8'h63);
      repeat (8) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      #1;
      check_all_zero("async_abort");
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      pulse_start(8'h63, 8'h63); wait_idle(200);

      // back-to-back with start held high: three sweeps
      @(negedge clk);
      f_num = 8'h63;
      expected = 8'h63;
      for (int i = 0; i < 3; i++) exp_q.push_back(model(8'h63, 8'h63, S));
      b2b = 1'b1;
      last_done = -1;
      start = 1'b1;
      begin
         int n;
         n = 0;
         while (exp_q.size() > 1 && n < 300) begin
            @(negedge clk);
            n++;
         end
         if (n >= 300) check("b2b_timeout", 32'd1, 32'd0);
      end
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      wait_idle(200);
      b2b = 1'b0;

      // SETTLE_CYCLES = 1 with a 3-cycle gate: samples lag one row
      @(negedge clk);
      start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      begin
         int n;
         n = 0;
         while (!done_s && n < 100) begin
            @(negedge clk);
            n++;
         end
         check("slow_done_seen", {31'd0, done_s}, 32'd1);
      end
`ifdef TT_SWEEP_EARLY_ABORT_EN
      check("slow_table", {24'd0, table_s}, 32'h00);
`else
      check("slow_table", {24'd0, table_s}, 32'h31);
`endif
      check("slow_fail",     {31'd0, fail_s},     32'd1);
      check("slow_fail_row", {29'd0, fail_row_s}, 32'd1);
      check("slow_match",    {31'd0, match_s},    32'd0);

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
      $finish;
   end

endmodule
